// File: rtl/timer_mmio.sv
// Memory-mapped down-counting timer with one-shot/auto-reload modes and an expiry flag.
// Optional build macro TIMER_MMIO_IRQ_EN implements CTRL.IE and drives irq = EXP & IE.
module timer_mmio #(
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q;
  logic               en_q;
  logic               auto_q;
  logic               exp_q;
  logic [WIDTH-1:0]   load_q;
  logic [WIDTH-1:0]   count_q;
  logic [PW-1:0]      presc_q;
  logic               ieRd;

  logic ctrlWr;
  logic loadWr;
  logic statClr;
  logic tick;

  assign ctrlWr  = we && (addr == 2'd0);
  assign loadWr  = we && (addr == 2'd1);
  assign statClr = we && (addr == 2'd3) && wd[0];
  assign tick    = (presc_q == PW'(PRESCALE - 1));

`ifdef TIMER_MMIO_IRQ_EN
  logic ie_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      ie_q <= 1'b0;
    else if (ctrlWr) ie_q <= wd[2];
  end

  assign ieRd = ie_q;
  assign irq  = exp_q & ie_q;
`else
  assign ieRd = 1'b0;
  assign irq  = 1'b0;
`endif

  // A CTRL write takes priority over the tick on the same edge; expiry set
  // is placed after the STAT clear so that set wins when both coincide.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      auto_q  <= 1'b0;
      exp_q   <= 1'b0;
      load_q  <= '0;
      count_q <= '0;
      presc_q <= '0;
    end else begin
      if (loadWr)  load_q <= WIDTH'(wd);
      if (statClr) exp_q  <= 1'b0;
      if (ctrlWr) begin
        en_q   <= wd[0];
        auto_q <= wd[1];
        if (wd[0]) begin
          state_q <= RUN;
          count_q <= load_q;
          presc_q <= '0;
        end else if (state_q == RUN) begin
          state_q <= IDLE;
        end
      end else if (state_q == RUN) begin
        presc_q <= tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          if (count_q != '0) begin
            count_q <= count_q - 1'b1;
          end else begin
            exp_q <= 1'b1;
            if (auto_q) begin
              count_q <= load_q;
            end else begin
              state_q <= DONE;
              en_q    <= 1'b0;
            end
          end
        end
      end
    end
  end

  always_comb begin
    rd = '0;
    case (addr)
      2'd0:    rd = {29'b0, ieRd, auto_q, en_q};
      2'd1:    rd = 32'(load_q);
      2'd2:    rd = 32'(count_q);
      default: rd = {31'b0, exp_q};
    endcase
  end

endmodule

// File: tb/tb_timer_mmio.sv
// Self-checking bench for timer_mmio: expiry latencies go through a scoreboard queue,
// register reads are compared against bench-derived constants.
module tb_timer_mmio;

  logic        clock;
  logic        reset;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

`ifdef TIMER_MMIO_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] value;
  } expect_t;

  expect_t sb[$];

  timer_mmio #(.WIDTH(32), .PRESCALE(4)) dut (
    .clock(clock),
    .reset(reset),
    .we(we),
    .addr(addr),
    .wd(wd),
    .rd(rd),
    .irq(irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic expectValue(input string tag, input logic [31:0] value);
    expect_t e;
    e.tag   = tag;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic observe(input logic [31:0] value);
    expect_t e;
    if (sb.size() == 0) begin
      checkOutput("sb_empty", value, 32'hFFFF_FFFF);
    end else begin
      e = sb.pop_front();
      checkOutput(e.tag, value, e.value);
    end
  endtask

  // Write commits on the next rising edge; returns that edge's cycle number.
  task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d, output int edgeCyc);
    @(negedge clock);
    we   = 1'b1;
    addr = a;
    wd   = d;
    @(posedge clock);
    #1;
    we = 1'b0;
    edgeCyc = cyc;
  endtask

  task automatic readReg(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rd;
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Polls EXP each cycle and feeds the observed latency to the scoreboard.
  task automatic waitExpiry(input int start, input int budget);
    logic [31:0] v;
    readReg(2'd3, v);
    while (v[0] !== 1'b1 && (cyc - start) < budget) begin
      @(posedge clock);
      #1;
      readReg(2'd3, v);
    end
    observe(v[0] ? 32'(cyc - start) : 32'hDEAD_BEEF);
  endtask

  initial begin
    logic [31:0] v;
    int t0;
    int e;

    reset = 1'b0;
    we    = 1'b0;
    addr  = 2'd0;
    wd    = '0;
    repeat (3) @(posedge clock);
    #1;
    for (int a = 0; a < 4; a++) begin
      readReg(a[1:0], v);
      checkOutput($sformatf("reset_rd%0d", a), v, 32'h0);
    end
    checkOutput("reset_irq", {31'b0, irq}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // One-shot with LOAD=3
    applyStimulus(2'd1, 32'd3, e);
    readReg(2'd1, v);
    checkOutput("load_rb", v, 32'd3);
    expectValue("oneshot_lat", 32'd16);
    applyStimulus(2'd0, 32'h1, t0);
    readReg(2'd0, v);
    checkOutput("oneshot_ctrl_run", v, 32'h1);
    waitExpiry(t0, 200);
    readReg(2'd0, v);
    checkOutput("oneshot_ctrl_done", v, 32'h0);
    readReg(2'd2, v);
    checkOutput("oneshot_count", v, 32'h0);
    repeat (8) @(posedge clock);
    #1;
    readReg(2'd2, v);
    checkOutput("done_count_hold", v, 32'h0);
    applyStimulus(2'd3, 32'h0, e);
    readReg(2'd3, v);
    checkOutput("stat_w0_noop", v, 32'h1);
    applyStimulus(2'd3, 32'h1, e);
    readReg(2'd3, v);
    checkOutput("stat_clear", v, 32'h0);

    // Auto-reload with IE, LOAD=1
    applyStimulus(2'd1, 32'd1, e);
    expectValue("auto_lat1", 32'd8);
    applyStimulus(2'd0, 32'h7, t0);
    waitExpiry(t0, 200);
    checkOutput("auto_irq", {31'b0, irq}, {31'b0, IRQ_BUILD});
    readReg(2'd0, v);
    checkOutput("auto_ctrl", v, IRQ_BUILD ? 32'h7 : 32'h3);
    readReg(2'd2, v);
    checkOutput("auto_reload", v, 32'd1);
    applyStimulus(2'd3, 32'h1, e);
    checkOutput("irq_cleared", {31'b0, irq}, 32'h0);
    expectValue("auto_lat2", 32'd16);
    waitExpiry(t0, 200);

    // STAT clear on the same edge as an expiry: set wins
    waitUntil(t0 + 16);
    applyStimulus(2'd3, 32'h1, e);
    readReg(2'd3, v);
    checkOutput("pre_clear", v, 32'h0);
    waitUntil(t0 + 23);
    applyStimulus(2'd3, 32'h1, e);
    checkOutput("same_edge_cyc", 32'(e - t0), 32'd24);
    readReg(2'd3, v);
    checkOutput("same_edge_exp", v, 32'h1);

    // Stop from RUN: COUNT holds at its reload value
    applyStimulus(2'd0, 32'h0, e);
    repeat (8) @(posedge clock);
    #1;
    readReg(2'd2, v);
    checkOutput("idle_count_hold", v, 32'd1);
    readReg(2'd0, v);
    checkOutput("idle_ctrl", v, 32'h0);
    applyStimulus(2'd3, 32'h1, e);

    // LOAD changed mid-run only affects the next reload
    applyStimulus(2'd1, 32'd3, e);
    expectValue("reload_lat1", 32'd16);
    applyStimulus(2'd0, 32'h3, t0);
    waitUntil(t0 + 4);
    applyStimulus(2'd1, 32'd7, e);
    waitExpiry(t0, 200);
    waitUntil(t0 + 16);
    applyStimulus(2'd3, 32'h1, e);
    expectValue("reload_lat2", 32'd48);
    waitExpiry(t0, 200);
    applyStimulus(2'd0, 32'h0, e);
    applyStimulus(2'd3, 32'h1, e);

    // LOAD=0 expires on the first tick
    applyStimulus(2'd1, 32'd0, e);
    expectValue("load0_lat", 32'd4);
    applyStimulus(2'd0, 32'h1, t0);
    waitExpiry(t0, 200);
    applyStimulus(2'd3, 32'h1, e);

    // Asynchronous reset in the middle of a run
    applyStimulus(2'd1, 32'd5, e);
    applyStimulus(2'd0, 32'h7, t0);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    for (int a = 0; a < 4; a++) begin
      readReg(a[1:0], v);
      checkOutput($sformatf("async_rd%0d", a), v, 32'h0);
    end
    checkOutput("async_irq", {31'b0, irq}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    repeat (24) @(posedge clock);
    #1;
    readReg(2'd3, v);
    checkOutput("post_reset_idle", v, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
